// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Constants and types shared by the fighter HP / round-outcome
//            logic and its neighbours in the scene pipeline.
// Contents : HP_MAX, BULLET_DMG, BULLET_DMG_DEF, IFRAME_TICKS, HP_W,
//            round_state_e, is_end_state()
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int HP_MAX         = 100; // starting / maximum HP per fighter
  localparam int BULLET_DMG     = 10;  // damage of an unblocked hit
  localparam int BULLET_DMG_DEF = 3;   // damage of a hit while defending
  localparam int IFRAME_TICKS   = 30;  // post-hit invulnerability, in frame ticks
  localparam int HP_W           = 7;   // width of an HP value

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIGHT     = 3'd1,
    KO_PLAYER = 3'd2,  // enemy wins
    KO_ENEMY  = 3'd3,  // player wins
    DRAW      = 3'd4
  } round_state_e;

  // True for every state in which the round has been decided.
  function automatic logic is_end_state(input round_state_e s);
    return (s == KO_PLAYER) || (s == KO_ENEMY) || (s == DRAW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hp_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : hp_tracker_if
// Purpose  : Bundles the game-step, hit and defend inputs and the HP / round
//            outputs of hp_tracker.
// Modports : master - drives frame_tick, round_start, hit*, def*;
//                     observes hp*, inv*, state, roundOver
//            slave  - the hp_tracker side (mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
interface hp_tracker_if;
  import game_pkg::*;

  logic              frame_tick;
  logic              round_start;
  logic              hitPlayer;
  logic              hitEnemy;
  logic              defPlayer;
  logic              defEnemy;
  logic [HP_W-1:0]   hpPlayer;
  logic [HP_W-1:0]   hpEnemy;
  logic              invPlayer;
  logic              invEnemy;
  round_state_e      state;
  logic              roundOver;

  modport master (
    output frame_tick, round_start, hitPlayer, hitEnemy, defPlayer, defEnemy,
    input  hpPlayer, hpEnemy, invPlayer, invEnemy, state, roundOver
  );

  modport slave (
    input  frame_tick, round_start, hitPlayer, hitEnemy, defPlayer, defEnemy,
    output hpPlayer, hpEnemy, invPlayer, invEnemy, state, roundOver
  );

endinterface
`default_nettype wire

// File: rtl/hp_channel.sv
`default_nettype none
// ============================================================================
// Module   : hp_channel
// Purpose  : One fighter's HP register with saturating damage and a
//            post-hit invulnerability counter.
// Ports    : clk, rst_n          - clock, async active-low reset
//            load                - reload HP to HP_MAX, clear counter
//            hit, defend         - hit pulse, victim defending (level)
//            enable              - hits are accepted only while high
//            frame_tick          - game-step strobe, decrements counter
//            hp, inv             - registered HP, invulnerable flag
//            hp_next_zero        - HP will be 0 after this edge
// Revision : 1.0 - initial release
// ============================================================================
module hp_channel
  import game_pkg::*;
#(
  parameter int HP_MAX       = game_pkg::HP_MAX,
  parameter int DMG          = game_pkg::BULLET_DMG,
  parameter int DMG_DEF      = game_pkg::BULLET_DMG_DEF,
  parameter int IFRAME_TICKS = game_pkg::IFRAME_TICKS
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            load,
  input  wire logic            hit,
  input  wire logic            defend,
  input  wire logic            enable,
  input  wire logic            frame_tick,
  output logic [HP_W-1:0]      hp,
  output logic                 inv,
  output logic                 hp_next_zero
);

  localparam int CNT_W = (IFRAME_TICKS < 1) ? 1 : $clog2(IFRAME_TICKS + 1);

  localparam logic [HP_W-1:0]  c_hp_max  = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0]  c_dmg     = HP_W'(DMG);
  localparam logic [HP_W-1:0]  c_dmg_def = HP_W'(DMG_DEF);
  localparam logic [CNT_W-1:0] c_iframe  = CNT_W'(IFRAME_TICKS);

  logic [HP_W-1:0]  r_hp;
  logic [HP_W-1:0]  w_hp_next;
  logic [HP_W-1:0]  w_dmg;
  logic [HP_W-1:0]  w_hp_sub;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accept;

  always_comb begin
    w_accept   = enable && hit && (r_cnt == '0);
    w_dmg      = defend ? c_dmg_def : c_dmg;
    // Clamp at zero instead of letting the 7-bit value wrap.
    w_hp_sub   = (r_hp > w_dmg) ? (r_hp - w_dmg) : '0;
    w_hp_next  = r_hp;
    w_cnt_next = r_cnt;
    if (load) begin
      w_hp_next  = c_hp_max;
      w_cnt_next = '0;
    end else if (w_accept) begin
      // An accepted hit reloads the counter even if frame_tick is also high.
      w_hp_next  = w_hp_sub;
      w_cnt_next = c_iframe;
    end else if (frame_tick && (r_cnt != '0)) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hp  <= c_hp_max;
      r_cnt <= '0;
    end else begin
      r_hp  <= w_hp_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign hp           = r_hp;
  assign inv          = (r_cnt != '0);
  assign hp_next_zero = (w_hp_next == '0);

endmodule
`default_nettype wire

// File: rtl/hp_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hp_tracker
// Purpose  : Damage and round-outcome stage behind the bullet blocks. Keeps
//            both fighters' HP and invulnerability windows and runs the
//            round FSM (IDLE / FIGHT / KO_PLAYER / KO_ENEMY / DRAW).
// Ports    : clk, rst_n  - clock, async active-low reset
//            bus (slave) - frame_tick, round_start, hitPlayer, hitEnemy,
//                          defPlayer, defEnemy in; hpPlayer, hpEnemy,
//                          invPlayer, invEnemy, state, roundOver out
// Revision : 1.0 - initial release
// ============================================================================
module hp_tracker
  import game_pkg::*;
#(
  parameter int HP_MAX       = game_pkg::HP_MAX,
  parameter int DMG          = game_pkg::BULLET_DMG,
  parameter int DMG_DEF      = game_pkg::BULLET_DMG_DEF,
  parameter int IFRAME_TICKS = game_pkg::IFRAME_TICKS
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  hp_tracker_if.slave   bus
);

  round_state_e    r_state;
  round_state_e    w_state_next;
  logic            w_enable;
  logic            w_load;
  logic [HP_W-1:0] w_hp_player;
  logic [HP_W-1:0] w_hp_enemy;
  logic            w_inv_player;
  logic            w_inv_enemy;
  logic            w_zero_player;
  logic            w_zero_enemy;

  // round_start reloads from every state, including a restart mid-fight.
  assign w_load   = bus.round_start;
  assign w_enable = (r_state == FIGHT);

  hp_channel #(
    .HP_MAX       (HP_MAX),
    .DMG          (DMG),
    .DMG_DEF      (DMG_DEF),
    .IFRAME_TICKS (IFRAME_TICKS)
  ) u_player (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (w_load),
    .hit          (bus.hitPlayer),
    .defend       (bus.defPlayer),
    .enable       (w_enable),
    .frame_tick   (bus.frame_tick),
    .hp           (w_hp_player),
    .inv          (w_inv_player),
    .hp_next_zero (w_zero_player)
  );

  hp_channel #(
    .HP_MAX       (HP_MAX),
    .DMG          (DMG),
    .DMG_DEF      (DMG_DEF),
    .IFRAME_TICKS (IFRAME_TICKS)
  ) u_enemy (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (w_load),
    .hit          (bus.hitEnemy),
    .defend       (bus.defEnemy),
    .enable       (w_enable),
    .frame_tick   (bus.frame_tick),
    .hp           (w_hp_enemy),
    .inv          (w_inv_enemy),
    .hp_next_zero (w_zero_enemy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outcome is decided from next-cycle HP so the KO/DRAW state appears on
  // the same edge as the killing hit.
  always_comb begin
    w_state_next = r_state;
    if (bus.round_start) begin
      w_state_next = FIGHT;
    end else begin
      unique case (r_state)
        FIGHT: begin
          if (w_zero_player && w_zero_enemy) begin
            w_state_next = DRAW;
          end else if (w_zero_player) begin
            w_state_next = KO_PLAYER;
          end else if (w_zero_enemy) begin
            w_state_next = KO_ENEMY;
          end
        end
        IDLE, KO_PLAYER, KO_ENEMY, DRAW: w_state_next = r_state;
        default:                         w_state_next = IDLE;
      endcase
    end
  end

  assign bus.hpPlayer  = w_hp_player;
  assign bus.hpEnemy   = w_hp_enemy;
  assign bus.invPlayer = w_inv_player;
  assign bus.invEnemy  = w_inv_enemy;
  assign bus.state     = r_state;
  assign bus.roundOver = is_end_state(r_state);

endmodule
`default_nettype wire
